// File: rtl/vga_matrix_text_renderer_pkg.sv
// Shared constants and types for the VGA matrix text renderer.
package vga_matrix_text_renderer_pkg;

    localparam logic [3:0] BLANK_CODE     = 4'hA;
    localparam int         GLYPH_W        = 8;
    localparam int         GLYPH_H        = 16;
    localparam int         FIELD_CH       = 8;
    localparam int         RENDER_LATENCY = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        STORE   = 2'd2
    } wr_state_e;

endpackage

// File: rtl/vga_matrix_text_renderer_bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
// done flags the final shift; bcd_out holds the result from the next cycle on.
module bin_to_bcd_seq
    import vga_matrix_text_renderer_pkg::*;
#(
    parameter int VAL_W  = 16,
    parameter int DIGITS = 5
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [VAL_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd_out
);

    localparam int             CNT_W = $clog2(VAL_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(VAL_W - 1);

    logic                  active_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [VAL_W-1:0]      sh_q;
    logic [DIGITS*4-1:0]   bcd_q;
    logic [DIGITS*4-1:0]   bcd_adj;

    function automatic logic [DIGITS*4-1:0] dabble_adjust(input logic [DIGITS*4-1:0] v);
        logic [DIGITS*4-1:0] res;
        logic [3:0]          nib;
        res = '0;
        for (int d = 0; d < DIGITS; d++) begin
            nib = v[d*4 +: 4];
            res[d*4 +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
        return res;
    endfunction

    assign bcd_adj = dabble_adjust(bcd_q);
    assign busy    = active_q;
    assign done    = active_q && (cnt_q == LAST);
    assign bcd_out = bcd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else if (start) begin
            active_q <= 1'b1;
            cnt_q    <= '0;
        end else if (active_q) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST)
                active_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            sh_q  <= bin_in;
            bcd_q <= '0;
        end else if (active_q) begin
            bcd_q <= {bcd_adj[DIGITS*4-2:0], sh_q[VAL_W-1]};
            sh_q  <= {sh_q[VAL_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/vga_matrix_text_renderer.sv
// Renders the result matrix as decimal text on a 640x480 raster via an external glyph ROM.
// Optional element highlight (swapped colours) when VGA_TEXT_HIGHLIGHT_EN is defined.
module vga_matrix_text_renderer
    import vga_matrix_text_renderer_pkg::*;
#(
    parameter int          MAT_DIM  = 3,
    parameter int          VAL_W    = 16,
    parameter int          DIGITS   = 5,
    parameter int          ORIGIN_X = 64,
    parameter int          ORIGIN_Y = 64,
    parameter logic [11:0] FG_COLOR = 12'hFFF,
    parameter logic [11:0] BG_COLOR = 12'h000
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [9:0]       h_count,
    input  logic [9:0]       v_count,
    input  logic             video_on,
    input  logic             hsync_in,
    input  logic             vsync_in,
`ifdef VGA_TEXT_HIGHLIGHT_EN
    input  logic [3:0]       sel_idx,
`endif
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [3:0]       wr_idx,
    input  logic [VAL_W-1:0] wr_value,
    output logic             busy,
    output logic [3:0]       rom_digit_code,
    output logic [3:0]       rom_row,
    output logic [2:0]       rom_col,
    input  logic             rom_pixel,
    output logic [11:0]      rgb,
    output logic             hsync_out,
    output logic             vsync_out
);

    localparam int N_ELEM   = MAT_DIM * MAT_DIM;
    localparam int COL_W    = $clog2(GLYPH_W);
    localparam int ROW_W    = $clog2(GLYPH_H);
    localparam int CH_W     = $clog2(FIELD_CH);
    localparam int FIELD_SH = $clog2(FIELD_CH * GLYPH_W);
    localparam int ROW_SH   = $clog2(2 * GLYPH_H);

    localparam logic [9:0]      OX     = 10'(ORIGIN_X);
    localparam logic [9:0]      OY     = 10'(ORIGIN_Y);
    localparam logic [9:0]      MD10   = 10'(MAT_DIM);
    localparam logic [3:0]      MD4    = 4'(MAT_DIM);
    localparam logic [CH_W:0]   DIG_N  = (CH_W+1)'(DIGITS);
    localparam logic [CH_W-1:0] MSD_CH = CH_W'(DIGITS - 1);

    function automatic logic [DIGITS*4-1:0] blank_leading(input logic [DIGITS*4-1:0] bcd);
        logic [DIGITS*4-1:0] res;
        logic                seen;
        seen = 1'b0;
        res  = bcd;
        for (int d = DIGITS - 1; d > 0; d--) begin
            if (bcd[d*4 +: 4] != 4'd0)
                seen = 1'b1;
            res[d*4 +: 4] = seen ? bcd[d*4 +: 4] : BLANK_CODE;
        end
        return res;
    endfunction

    function automatic logic [11:0] pix_color(input logic on);
        return on ? FG_COLOR : BG_COLOR;
    endfunction

    // Write path: handshake, sequential conversion, single-cycle store
    wr_state_e             state_q, state_d;
    logic                  hs;
    logic                  conv_busy, conv_done;
    logic [DIGITS*4-1:0]   conv_bcd;
    logic [DIGITS*4-1:0]   store_digits;
    logic [3:0]            wr_idx_q;
    logic [3:0]            digit_buf_q [N_ELEM][DIGITS];

    assign wr_ready     = rst_n && (state_q == IDLE);
    assign hs           = wr_valid && wr_ready;
    assign busy         = (state_q != IDLE) || conv_busy;
    assign store_digits = blank_leading(conv_bcd);

    bin_to_bcd_seq #(
        .VAL_W  (VAL_W),
        .DIGITS (DIGITS)
    ) u_bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (hs),
        .bin_in  (wr_value),
        .busy    (conv_busy),
        .done    (conv_done),
        .bcd_out (conv_bcd)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hs)        state_d = CONVERT;
            CONVERT: if (conv_done) state_d = STORE;
            STORE:                  state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (hs)
            wr_idx_q <= wr_idx;
    end

    // An out-of-range index matches no element, so STORE is a no-op for it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < N_ELEM; e++)
                for (int d = 0; d < DIGITS; d++)
                    digit_buf_q[e][d] <= BLANK_CODE;
        end else if (state_q == STORE) begin
            for (int e = 0; e < N_ELEM; e++)
                if (4'(e) == wr_idx_q)
                    for (int d = 0; d < DIGITS; d++)
                        digit_buf_q[e][d] <= store_digits[d*4 +: 4];
        end
    end

    // Stage p0: raster decode, origin compared before subtracting
    logic              h_ge, v_ge, gap_c, field_c, text_c;
    logic [9:0]        dx, dy, ec_w, er_w;
    logic [CH_W-1:0]   ch_c;
    logic [3:0]        elem_c;

    assign h_ge    = h_count >= OX;
    assign v_ge    = v_count >= OY;
    assign dx      = h_count - OX;
    assign dy      = v_count - OY;
    assign ec_w    = dx >> FIELD_SH;
    assign er_w    = dy >> ROW_SH;
    assign ch_c    = dx[COL_W +: CH_W];
    assign gap_c   = dy[ROW_W];
    assign field_c = h_ge && v_ge && (ec_w < MD10) && (er_w < MD10) && !gap_c;
    assign text_c  = field_c && ({1'b0, ch_c} < DIG_N);
    assign elem_c  = er_w[3:0] * MD4 + ec_w[3:0];

    // Stage p1: registered decode
    logic              text_p1, vld_p1, vld_p2, vld_p3;
    logic [3:0]        elem_p1;
    logic [CH_W-1:0]   ch_p1, dsel_p1;
    logic [ROW_W-1:0]  row_p1;
    logic [COL_W-1:0]  col_p1;
    logic              hl_p3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            text_p1 <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            vld_p3  <= 1'b0;
        end else begin
            text_p1 <= text_c;
            vld_p1  <= video_on;
            vld_p2  <= vld_p1;
            vld_p3  <= vld_p2;
        end
    end

    always_ff @(posedge clk) begin
        elem_p1 <= elem_c;
        ch_p1   <= ch_c;
        row_p1  <= dy[ROW_W-1:0];
        col_p1  <= dx[COL_W-1:0];
    end

`ifdef VGA_TEXT_HIGHLIGHT_EN
    localparam logic [4:0] N5 = 5'(N_ELEM);
    logic hl_c, hl_p1, hl_p2, hl_q3;

    assign hl_c  = field_c && (elem_c == sel_idx) && ({1'b0, sel_idx} < N5);
    assign hl_p3 = hl_q3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hl_p1 <= 1'b0;
            hl_p2 <= 1'b0;
            hl_q3 <= 1'b0;
        end else begin
            hl_p1 <= hl_c;
            hl_p2 <= hl_p1;
            hl_q3 <= hl_p2;
        end
    end
`else
    assign hl_p3 = 1'b0;
`endif

    // Stage p2: buffer read into the ROM request; character 0 is the most significant digit
    assign dsel_p1 = MSD_CH - ch_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_digit_code <= BLANK_CODE;
            rom_row        <= '0;
            rom_col        <= '0;
        end else begin
            rom_digit_code <= text_p1 ? digit_buf_q[elem_p1][dsel_p1] : BLANK_CODE;
            rom_row        <= row_p1;
            rom_col        <= col_p1;
        end
    end

    // Stage p3 -> output: colour from the ROM pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rgb <= 12'h000;
        else
            rgb <= vld_p3 ? pix_color(rom_pixel ^ hl_p3) : 12'h000;
    end

    logic [1:0] sync_pipe [RENDER_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RENDER_LATENCY; i++)
                sync_pipe[i] <= 2'b00;
        end else begin
            sync_pipe[0] <= {hsync_in, vsync_in};
            for (int i = 1; i < RENDER_LATENCY; i++)
                sync_pipe[i] <= sync_pipe[i-1];
        end
    end

    assign hsync_out = sync_pipe[RENDER_LATENCY-1][1];
    assign vsync_out = sync_pipe[RENDER_LATENCY-1][0];

endmodule

// File: tb/tb_vga_matrix_text_renderer.sv
// Scoreboard bench for vga_matrix_text_renderer with a behavioural registered glyph ROM.
module tb_vga_matrix_text_renderer;

    localparam logic [3:0] BLANK = 4'hA;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  h_count = 10'd700;
    logic [9:0]  v_count = 10'd500;
    logic        video_on = 1'b0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [3:0]  wr_idx = 4'd0;
    logic [15:0] wr_value = 16'd0;
    logic        busy;
    logic [3:0]  rom_digit_code;
    logic [3:0]  rom_row;
    logic [2:0]  rom_col;
    logic        rom_pixel = 1'b0;
    logic [11:0] rgb;
    logic        hsync_out;
    logic        vsync_out;
`ifdef VGA_TEXT_HIGHLIGHT_EN
    logic [3:0]  sel_idx = 4'd15;
`endif

    always #5 clk = ~clk;

    vga_matrix_text_renderer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .h_count        (h_count),
        .v_count        (v_count),
        .video_on       (video_on),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
`ifdef VGA_TEXT_HIGHLIGHT_EN
        .sel_idx        (sel_idx),
`endif
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_idx         (wr_idx),
        .wr_value       (wr_value),
        .busy           (busy),
        .rom_digit_code (rom_digit_code),
        .rom_row        (rom_row),
        .rom_col        (rom_col),
        .rom_pixel      (rom_pixel),
        .rgb            (rgb),
        .hsync_out      (hsync_out),
        .vsync_out      (vsync_out)
    );

    typedef struct {
        int         due;
        logic [3:0] code;
        logic [3:0] row;
        logic [2:0] col;
        logic       chk_rc;
    } req_t;

    typedef struct {
        int          due;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } out_t;

    req_t       req_q[$];
    out_t       out_q[$];
    int         model_buf [9][5];
    logic [3:0] last_code = BLANK;
    logic [3:0] last_row = 4'd0;
    logic [2:0] last_col = 3'd0;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic glyph(input logic [3:0] c, input logic [3:0] r, input logic [2:0] k);
        int s;
        if (c > 4'd9) return 1'b0;
        s = int'(c) * 7 + int'(r) * 3 + int'(k) * 5;
        return (s % 3) == 0;
    endfunction

    function automatic int mdig(input int v, input int d);
        int p = 1;
        for (int i = 0; i < d; i++) p *= 10;
        if (d > 0 && v < p) return 10;
        return (v / p) % 10;
    endfunction

    task automatic blank_model();
        for (int e = 0; e < 9; e++)
            for (int d = 0; d < 5; d++)
                model_buf[e][d] = 10;
    endtask

    // Called at a falling edge: serve the ROM, check due outputs, drive cycle inputs, push expectations
    task automatic tick(input int x, input int y, input logic vo, input logic hs, input logic vs);
        req_t       rq;
        out_t       oq;
        int         dx = 0, dy = 0, ec = 0, er = 0, ch = 0;
        logic       in_f = 1'b0, hl = 1'b0, pix;
        logic [3:0] code = BLANK;

        rom_pixel = glyph(last_code, last_row, last_col);
        last_code = rom_digit_code;
        last_row  = rom_row;
        last_col  = rom_col;

        while (req_q.size() > 0 && req_q[0].due <= cyc) begin
            rq = req_q.pop_front();
            check_val("rom_code", {28'd0, rom_digit_code}, {28'd0, rq.code});
            if (rq.chk_rc) begin
                check_val("rom_row", {28'd0, rom_row}, {28'd0, rq.row});
                check_val("rom_col", {29'd0, rom_col}, {29'd0, rq.col});
            end
        end
        while (out_q.size() > 0 && out_q[0].due <= cyc) begin
            oq = out_q.pop_front();
            check_val("rgb", {20'd0, rgb}, {20'd0, oq.rgb});
            check_val("hsync_out", {31'd0, hsync_out}, {31'd0, oq.hs});
            check_val("vsync_out", {31'd0, vsync_out}, {31'd0, oq.vs});
        end

        h_count  = 10'(x);
        v_count  = 10'(y);
        video_on = vo;
        hsync_in = hs;
        vsync_in = vs;

        if (x >= 64 && y >= 64) begin
            dx = x - 64;
            dy = y - 64;
            ec = dx / 64;
            ch = (dx / 8) % 8;
            er = dy / 32;
            in_f = (ec < 3) && (er < 3) && ((dy / 16) % 2 == 0);
            if (in_f && ch < 5) code = 4'(model_buf[er * 3 + ec][4 - ch]);
        end
`ifdef VGA_TEXT_HIGHLIGHT_EN
        hl = in_f && (er * 3 + ec == int'(sel_idx)) && (sel_idx < 4'd9);
`endif
        pix = glyph(code, 4'(dy % 16), 3'(dx % 8));

        rq.due = cyc + 2; rq.code = code; rq.row = 4'(dy % 16); rq.col = 3'(dx % 8);
        rq.chk_rc = in_f && (ch < 5);
        req_q.push_back(rq);
        oq.due = cyc + 4; oq.rgb = !vo ? 12'h000 : ((pix ^ hl) ? 12'hFFF : 12'h000);
        oq.hs = hs; oq.vs = vs;
        out_q.push_back(oq);

        @(negedge clk);
        cyc++;
    endtask

    task automatic idle();
        tick(700, 500, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic scan();
        int ys[13] = '{60, 64, 67, 79, 80, 96, 105, 112, 128, 140, 150, 159, 160};
        foreach (ys[i])
            for (int x = 40; x <= 280; x++)
                tick(x, ys[i], 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int x = 600; x <= 720; x++)
            tick(x, 470, x < 640, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 6; i++) idle();
    endtask

    task automatic do_reset(input int hold);
        rst_n = 1'b0;
        #1;
        check_val("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_rgb", {20'd0, rgb}, 32'd0);
        check_val("rst_code", {28'd0, rom_digit_code}, {28'd0, BLANK});
        check_val("rst_row_col", {25'd0, rom_row, rom_col}, 32'd0);
        check_val("rst_sync", {30'd0, hsync_out, vsync_out}, 32'd0);
        repeat (hold) begin @(negedge clk); cyc++; end
        rst_n = 1'b1;
        req_q.delete();
        out_q.delete();
        blank_model();
        last_code = BLANK; last_row = 4'd0; last_col = 3'd0; rom_pixel = 1'b0;
        #1;
        check_val("post_rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        check_val("post_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!wr_ready && n < 100) begin idle(); n++; end
        if (!wr_ready) check_val("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic count_low(input string tag);
        int n = 0;
        while (!wr_ready && n < 40) begin idle(); n++; end
        check_val(tag, n, 17);
    endtask

    task automatic model_store(input int idx, input int val);
        if (idx < 9)
            for (int d = 0; d < 5; d++) model_buf[idx][d] = mdig(val, d);
    endtask

    task automatic write_el(input int idx, input int val);
        wait_ready();
        wr_valid = 1'b1; wr_idx = 4'(idx); wr_value = 16'(val);
        idle();
        wr_valid = 1'b0;
        check_val("busy_after_hs", {31'd0, busy}, 32'd1);
        check_val("ready_after_hs", {31'd0, wr_ready}, 32'd0);
        count_low("ready_low_cycles");
        model_store(idx, val);
    endtask

    initial begin
        blank_model();
        @(negedge clk);
        do_reset(3);
        scan();

        write_el(0, 12345);
        scan();

        write_el(4, 7);
        write_el(8, 0);
        scan();

        // Out-of-range write with wr_valid held; the follow-on request must wait for wr_ready
        wait_ready();
        wr_valid = 1'b1; wr_idx = 4'd9; wr_value = 16'd99;
        idle();
        wr_idx = 4'd2; wr_value = 16'd42;
        check_val("hold_busy", {31'd0, busy}, 32'd1);
        count_low("hold_ready_low");
        check_val("hold_ready_back", {31'd0, wr_ready}, 32'd1);
        idle();
        wr_valid = 1'b0;
        check_val("second_accepted", {31'd0, busy}, 32'd1);
        count_low("second_ready_low");
        model_store(2, 42);
        scan();

        // Abort a conversion with reset
        wait_ready();
        wr_valid = 1'b1; wr_idx = 4'd1; wr_value = 16'd555;
        idle();
        wr_valid = 1'b0;
        repeat (5) idle();
        check_val("abort_busy_before", {31'd0, busy}, 32'd1);
        do_reset(2);
        repeat (25) idle();
        check_val("abort_busy_after", {31'd0, busy}, 32'd0);
        check_val("abort_ready_after", {31'd0, wr_ready}, 32'd1);
        scan();

`ifdef VGA_TEXT_HIGHLIGHT_EN
        write_el(0, 12345);
        sel_idx = 4'd0;
        scan();
        sel_idx = 4'd12;
        scan();
        sel_idx = 4'd15;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_matrix_text_renderer.md
Name: vga_matrix_text_renderer

Overview:
- Renders the MAT_DIM x MAT_DIM result matrix as decimal text on the 640x480 VGA raster.
- Accepts binary result values from the compute engine over a valid/ready port and converts each to BCD sequentially (double-dabble) into an internal digit buffer.
- Maps each raster coordinate to a glyph request (digit code, glyph row, glyph column) for the downstream digit glyph ROM, which has 1-cycle registered latency.
- Emits colour plus sync delayed to stay aligned with the ROM pixel.

Parameters:
- MAT_DIM, 3, matrix dimension; elements indexed 0..MAT_DIM*MAT_DIM-1, row-major.
- VAL_W, 16, result value width, unsigned.
- DIGITS, 5, decimal digits per element; must satisfy 10^DIGITS > 2^VAL_W - 1, and DIGITS <= 8.
- ORIGIN_X, 64, left edge of the text area in pixels; multiple of 8.
- ORIGIN_Y, 64, top edge of the text area in pixels; multiple of 16.
- FG_COLOR, 12'hFFF, glyph colour (RGB 4:4:4).
- BG_COLOR, 12'h000, background colour inside video_on.

Ports:
- clk  in  1  system clock (pixel clock domain).
- rst_n  in  1  asynchronous active-low reset.
- h_count  in  10  pixel x from the timing generator.
- v_count  in  10  pixel y from the timing generator.
- video_on  in  1  active-video flag.
- hsync_in  in  1  horizontal sync from the timing generator.
- vsync_in  in  1  vertical sync from the timing generator.
- wr_valid  in  1  result write request.
- wr_ready  out  1  block can accept a write.
- wr_idx  in  4  element index.
- wr_value  in  VAL_W  binary result value.
- busy  out  1  conversion in progress.
- rom_digit_code  out  4  glyph code to the ROM; 0..9, or BLANK = 4'hA.
- rom_row  out  4  glyph row to the ROM.
- rom_col  out  3  glyph column to the ROM.
- rom_pixel  in  1  glyph bit from the ROM, valid 1 cycle after the request.
- rgb  out  12  pixel colour.
- hsync_out  out  1  aligned horizontal sync.
- vsync_out  out  1  aligned vertical sync.

Behaviour:
- Reset values:
  - rgb = 0, hsync_out = 0, vsync_out = 0.
  - rom_digit_code = BLANK, rom_row = 0, rom_col = 0.
  - wr_ready = 0 during reset, 1 in the first cycle after release.
  - busy = 0; FSM = IDLE; every buffer digit = BLANK.
- Layout:
  - dx = h_count - ORIGIN_X, dy = v_count - ORIGIN_Y.
  - Element column ec = dx>>6; character in field ch = dx[5:3]; glyph column = dx[2:0].
  - Element row er = dy>>5; glyph row = dy[3:0]; dy[4] = 1 is an inter-row gap.
  - Text is drawn only when all of these hold: h_count >= ORIGIN_X, v_count >= ORIGIN_Y, ec < MAT_DIM, er < MAT_DIM, ch < DIGITS, dy[4] = 0. Otherwise the code sent is BLANK.
- Render pipeline (input cycle T):
  - T+1: registered coordinates and decode.
  - T+2: rom_digit_code/rom_row/rom_col registered from the buffer read.
  - T+3: rom_pixel returned by the ROM.
  - T+4: rgb registered: FG_COLOR if rom_pixel = 1, else BG_COLOR; 0 if the delayed video_on = 0.
  - hsync_out/vsync_out are hsync_in/vsync_in delayed exactly 4 cycles.
- Write FSM:
  - IDLE: wr_ready = 1. A handshake (wr_valid && wr_ready) latches wr_idx and wr_value → CONVERT.
  - CONVERT: VAL_W cycles of double-dabble with busy = 1 and wr_ready = 0. Add 3 to any BCD nibble >= 5, then shift left. → STORE.
  - STORE: all DIGITS digits of the element are written in one cycle. Leading zeros are replaced with BLANK; the least significant digit is always written, so value 0 shows "0". → IDLE.
  - Timing: handshake in cycle A, STORE in cycle A+VAL_W+1, new glyphs visible to reads and wr_ready = 1 in cycle A+VAL_W+2.
- Boundaries:
  - wr_idx >= MAT_DIM*MAT_DIM: handshake still completes and the FSM runs normally, but STORE writes nothing.
  - A render read in the same cycle as STORE returns the old digits; there is no tearing within an element.
  - wr_valid held during CONVERT is ignored until wr_ready rises.
  - Reset mid-conversion aborts the conversion, returns the FSM to IDLE and blanks the buffer.
  - h_count/v_count below the origin must not wrap into the text area; compare before subtracting.

Optional Feature:
- Macro: VGA_TEXT_HIGHLIGHT_EN.
- Enabled:
  - Adds input sel_idx[3:0].
  - Pixels inside the full field (all 8 characters x 16 rows) of element sel_idx render with FG_COLOR and BG_COLOR swapped.
  - sel_idx is sampled at T and pipelined with the coordinates.
  - sel_idx >= MAT_DIM*MAT_DIM highlights nothing.
- Disabled: the port is absent and there is no inversion.

Decomposition:
- Shared package holds:
  - BLANK_CODE = 4'hA.
  - Glyph size constants: GLYPH_W = 8, GLYPH_H = 16.
  - FIELD_CH = 8 and RENDER_LATENCY = 4.
  - Write FSM state enum {IDLE, CONVERT, STORE}.
- One sub-module: bin_to_bcd_seq, a sequential double-dabble converter with start/done, parameterised by VAL_W and DIGITS. The top keeps layout, buffer and pipeline.

Test Plan:
- Reset, then scan a frame with a behavioural ROM model → all rgb = BG_COLOR inside video_on, 0 outside; sync outputs are inputs delayed 4 cycles.
- Write idx 0 value 12345 → wr_ready low for 17 cycles. Then at x = 64..103, y = 64..79 the ROM requests are codes 1,2,3,4,5, and rgb follows rom_pixel 4 cycles after each coordinate.
- Write idx 4 value 7 → field at x = 128, y = 96 requests BLANK×4 then 7. Write idx 8 value 0 → BLANK×4 then 0.
- Write idx 9 value 99 with wr_valid held through busy → handshake completes, no buffer change, the second request is accepted only after wr_ready returns.
- Assert rst_n low during CONVERT of idx 1 → buffer is all BLANK, busy = 0 and wr_ready = 1 after release.
- With VGA_TEXT_HIGHLIGHT_EN, sel_idx = 0 and idx 0 = 12345 → colours inverted across x = 64..127, y = 64..79 only.
